// File: rtl/fetch_decode.sv
// Instruction fetch/decode: walks the PC through a synchronous imem, buffers words in a prefetch FIFO.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (opcodes 5-E flagged illegal and stop fetch like HALT).
module fetch_decode #(
    parameter logic [7:0]  RESET_PC   = 8'd10,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [3:0]  dec_op,
    output logic [1:0]  dec_rd,
    output logic [1:0]  dec_mode,
    output logic [7:0]  dec_operand,
    output logic [7:0]  dec_pc,
    output logic        dec_illegal,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        halted
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {RUN, HALTED} state_e;

    state_e        state_q;
    logic [7:0]    pc_q;
    logic          epoch_q, req_epoch_q, inflight_q, started_q;
    logic [7:0]    resp_pc_q;
    logic [15:0]   word_q [FIFO_DEPTH];
    logic [7:0]    wpc_q  [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          fifo_empty, resp_ok, stop_op, in_stop;
    logic          handshake, push, pop;
    logic [CW:0]   occ;
    logic [15:0]   head_word;
    logic [7:0]    head_pc;

    // An empty FIFO presents the arriving response directly, so a word is decodable the cycle it returns.
    always_comb begin
        fifo_empty = (count_q == '0);
        resp_ok    = imem_rvalid && inflight_q && (req_epoch_q == epoch_q) && (state_q == RUN);
        head_word  = fifo_empty ? imem_rdata : word_q[rd_ptr_q];
        head_pc    = fifo_empty ? resp_pc_q  : wpc_q[rd_ptr_q];
`ifdef DECODE_ILLEGAL_CHECK_EN
        stop_op    = (imem_rdata[15:12] == 4'hF) ||
                     ((imem_rdata[15:12] >= 4'h5) && (imem_rdata[15:12] <= 4'hE));
`else
        stop_op    = (imem_rdata[15:12] == 4'hF);
`endif
        in_stop    = resp_ok && stop_op;
        dec_valid  = !fifo_empty || resp_ok;
        handshake  = dec_valid && dec_ready;
        push       = resp_ok && !(fifo_empty && dec_ready);
        pop        = handshake && !fifo_empty;
        occ        = (CW+1)'(count_q) + (CW+1)'(resp_ok) - (CW+1)'(handshake);
        imem_req   = started_q && (state_q == RUN) && !in_stop && (occ < (CW+1)'(FIFO_DEPTH));
        imem_addr  = pc_q;
        halted     = (state_q == HALTED) || in_stop;
    end

    always_comb begin
        dec_op      = '0;
        dec_rd      = '0;
        dec_mode    = '0;
        dec_operand = '0;
        dec_pc      = '0;
        dec_illegal = 1'b0;
        if (dec_valid) begin
            dec_op      = head_word[15:12];
            dec_rd      = head_word[11:10];
            dec_mode    = head_word[9:8];
            dec_operand = head_word[7:0];
            dec_pc      = head_pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
            dec_illegal = (head_word[15:12] >= 4'h5) && (head_word[15:12] <= 4'hE);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            inflight_q  <= 1'b0;
            started_q   <= 1'b0;
            resp_pc_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            started_q  <= 1'b1;
            inflight_q <= imem_req;
            if (imem_req) begin
                req_epoch_q <= epoch_q;
                resp_pc_q   <= pc_q;
            end
            // Any handshake this cycle has already completed; the flush discards everything left.
            if (redirect_valid) begin
                pc_q     <= redirect_pc;
                epoch_q  <= ~epoch_q;
                state_q  <= RUN;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (imem_req) pc_q <= pc_q + 8'd1;
                if (in_stop) state_q <= HALTED;
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= imem_rdata;
            wpc_q[wr_ptr_q]  <= resp_pc_q;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios plus a randomized program-order reference model.
module tb_fetch_decode;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];

    logic        rst_n = 1'b0, dec_ready = 1'b0, redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        imem_req, dec_valid, dec_illegal, halted;
    logic [7:0]  imem_addr, dec_operand, dec_pc;
    logic [3:0]  dec_op;
    logic [1:0]  dec_rd, dec_mode;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;

    logic        rst2_n = 1'b0, fe_ready = 1'b1, fe_redir = 1'b0;
    logic [7:0]  fe_redir_pc = '0;
    logic        fe_req, fe_valid, fe_illegal, fe_halted;
    logic [7:0]  fe_addr, fe_operand, fe_pc;
    logic [3:0]  fe_op;
    logic [1:0]  fe_rd, fe_mode;
    logic        fe_rvalid = 1'b0;
    logic [15:0] fe_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    fetch_decode #(.RESET_PC(8'd10), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd), .dec_mode(dec_mode),
        .dec_operand(dec_operand), .dec_pc(dec_pc), .dec_illegal(dec_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    fetch_decode #(.RESET_PC(8'hFE), .FIFO_DEPTH(2)) dut_fe (
        .clk(clk), .rst_n(rst2_n), .imem_req(fe_req), .imem_addr(fe_addr),
        .imem_rdata(fe_rdata), .imem_rvalid(fe_rvalid), .dec_valid(fe_valid),
        .dec_ready(fe_ready), .dec_op(fe_op), .dec_rd(fe_rd), .dec_mode(fe_mode),
        .dec_operand(fe_operand), .dec_pc(fe_pc), .dec_illegal(fe_illegal),
        .redirect_valid(fe_redir), .redirect_pc(fe_redir_pc), .halted(fe_halted)
    );

    // Synchronous instruction memory: response exactly one cycle after each request.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= mem[imem_addr];
        fe_rvalid   <= fe_req;
        fe_rdata    <= mem[fe_addr];
    end

    task automatic fill_add();
        for (int unsigned i = 0; i < 256; i++) mem[i] = {4'h1, 12'($urandom)};
    endtask

    // Leaves the bench at mid-cycle of cycle 0 (rst_n just released, not yet sampled).
    task automatic do_reset();
        rst_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #4;
    endtask

    task automatic test_reset();
        fill_add();
        do_reset();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_cmp++; if (imem_addr !== 8'd10) begin n_err++; $display("FAIL reset_addr got %h exp 0a", imem_addr); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", dec_valid); end
        n_cmp++; if ({dec_op, dec_rd, dec_mode, dec_operand, dec_pc} !== 24'h0) begin
            n_err++; $display("FAIL reset_fields got %h exp 0", {dec_op, dec_rd, dec_mode, dec_operand, dec_pc}); end
        n_cmp++; if ({dec_illegal, halted} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {dec_illegal, halted}); end
    endtask

    task automatic test_basic();
        logic [3:0] eop;
        fill_add();
        mem[10] = 16'h0000; mem[11] = 16'h1201; mem[12] = 16'hF000;
        do_reset();
        dec_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1; #4;
            eop = (c == 2) ? 4'h0 : (c == 3) ? 4'h1 : (c == 4) ? 4'hF : 4'h0;
            n_cmp++; if (imem_req !== (c <= 3)) begin n_err++; $display("FAIL basic_req c=%0d got %b exp %b", c, imem_req, c <= 3); end
            n_cmp++; if (dec_valid !== (c >= 2 && c <= 4)) begin n_err++; $display("FAIL basic_valid c=%0d got %b", c, dec_valid); end
            n_cmp++; if (halted !== (c >= 4)) begin n_err++; $display("FAIL basic_halted c=%0d got %b exp %b", c, halted, c >= 4); end
            if (c >= 2 && c <= 4) begin
                n_cmp++; if (dec_pc !== 8'(8 + c)) begin n_err++; $display("FAIL basic_pc c=%0d got %h exp %h", c, dec_pc, 8'(8 + c)); end
                n_cmp++; if (dec_op !== eop) begin n_err++; $display("FAIL basic_op c=%0d got %h exp %h", c, dec_op, eop); end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] e;
        fill_add();
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1 dec_ready = (c >= 8); #4;
            if (c >= 3 && c <= 7) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req c=%0d got %b exp 0", c, imem_req); end
            end
            if (c >= 7) begin
                e = (c == 7) ? 8'd10 : 8'(10 + c - 8);
                n_cmp++; if (dec_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid c=%0d got %b exp 1", c, dec_valid); end
                n_cmp++; if (dec_pc !== e) begin n_err++; $display("FAIL stall_pc c=%0d got %h exp %h", c, dec_pc, e); end
                n_cmp++; if (dec_op !== mem[e][15:12]) begin n_err++; $display("FAIL stall_op c=%0d got %h exp %h", c, dec_op, mem[e][15:12]); end
            end
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_redirect();
        fill_add();
        do_reset();
        dec_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1 redirect_valid = (c == 4); redirect_pc = 8'h40; #4;
            if (c >= 2 && c <= 4) begin
                n_cmp++; if (dec_pc !== 8'(8 + c)) begin n_err++; $display("FAIL redir_pre_pc c=%0d got %h exp %h", c, dec_pc, 8'(8 + c)); end
            end
            if (c == 4) begin
                n_cmp++; if (imem_addr !== 8'd13) begin n_err++; $display("FAIL redir_inflight_addr got %h exp 0d", imem_addr); end
            end
            if (c == 5) begin
                n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid got %b exp 0", dec_valid); end
                n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h40}) begin
                    n_err++; $display("FAIL redir_req got %b/%h exp 1/40", imem_req, imem_addr); end
            end
            if (c >= 6) begin
                n_cmp++; if ({dec_valid, dec_pc} !== {1'b1, 8'(8'h40 + c - 6)}) begin
                    n_err++; $display("FAIL redir_post_pc c=%0d got %b/%h exp 1/%h", c, dec_valid, dec_pc, 8'(8'h40 + c - 6)); end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        fill_add();
        rst2_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst2_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1; #4;
            if (c >= 2) begin
                e = 8'hFE + 8'(c - 2);
                n_cmp++; if ({fe_valid, fe_pc} !== {1'b1, e}) begin
                    n_err++; $display("FAIL wrap_pc c=%0d got %b/%h exp 1/%h", c, fe_valid, fe_pc, e); end
            end
        end
    endtask

    task automatic test_illegal();
        fill_add();
        mem[11] = 16'h7000;
        do_reset();
        dec_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1; #4;
            if (c == 3) begin
                n_cmp++; if ({dec_valid, dec_pc, dec_op} !== {1'b1, 8'd11, 4'h7}) begin
                    n_err++; $display("FAIL ill_head got %b/%h/%h exp 1/0b/7", dec_valid, dec_pc, dec_op); end
                n_cmp++; if (dec_illegal !== ILL_EN) begin n_err++; $display("FAIL ill_flag got %b exp %b", dec_illegal, ILL_EN); end
                n_cmp++; if (halted !== ILL_EN) begin n_err++; $display("FAIL ill_halted got %b exp %b", halted, ILL_EN); end
            end
            if (c == 4) begin
                n_cmp++; if ({dec_valid, dec_pc} !== (ILL_EN ? 9'h000 : {1'b1, 8'd12})) begin
                    n_err++; $display("FAIL ill_next got %b/%h exp illegal_en=%b", dec_valid, dec_pc, ILL_EN); end
                n_cmp++; if (imem_req !== !ILL_EN) begin n_err++; $display("FAIL ill_req got %b exp %b", imem_req, !ILL_EN); end
            end
        end
    endtask

    task automatic test_midreset();
        fill_add();
        mem[11] = 16'hF000;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1 rst_n = (c != 6); #4;
            if (c == 5) begin
                n_cmp++; if ({halted, dec_valid, imem_req} !== 3'b110) begin
                    n_err++; $display("FAIL mrst_pre got %b exp 110", {halted, dec_valid, imem_req}); end
            end
            if (c == 7) begin
                n_cmp++; if ({imem_req, imem_addr, dec_valid, halted, dec_illegal} !== {1'b0, 8'd10, 3'b000}) begin
                    n_err++; $display("FAIL mrst_ctl got %b/%h/%b%b%b", imem_req, imem_addr, dec_valid, halted, dec_illegal); end
                n_cmp++; if ({dec_op, dec_rd, dec_mode, dec_operand, dec_pc} !== 24'h0) begin
                    n_err++; $display("FAIL mrst_fields got %h exp 0", {dec_op, dec_rd, dec_mode, dec_operand, dec_pc}); end
            end
            if (c == 8) begin
                n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'd10}) begin
                    n_err++; $display("FAIL mrst_restart got %b/%h exp 1/0a", imem_req, imem_addr); end
            end
            if (c == 9) begin
                n_cmp++; if ({dec_valid, dec_pc} !== {1'b1, 8'd10}) begin
                    n_err++; $display("FAIL mrst_first got %b/%h exp 1/0a", dec_valid, dec_pc); end
            end
        end
    endtask

    // Reference: instructions must leave in program order from the current PC, restarting at each
    // redirect target and stopping after a consumed HALT (or illegal opcode when the check is enabled).
    task automatic test_random();
        logic [7:0]  exp_pc;
        logic [15:0] w;
        logic [3:0]  op;
        bit          m_halted, stop;
        int          nhs;
        for (int unsigned i = 0; i < 256; i++) begin
            int unsigned r = $urandom_range(0, 31);
            op = (r < 26) ? 4'(r % 5) : (r < 28) ? 4'hF : 4'(5 + $urandom_range(0, 9));
            mem[i] = {op, 12'($urandom)};
        end
        do_reset();
        exp_pc = 8'd10; m_halted = 1'b0; nhs = 0;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            dec_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            redirect_pc    = 8'($urandom);
            #4;
            if (m_halted) begin
                n_cmp++; if ({dec_valid, imem_req, halted} !== 3'b001) begin
                    n_err++; $display("FAIL rnd_halted c=%0d got v/req/h=%b exp 001", c, {dec_valid, imem_req, halted}); end
            end else if (dec_valid) begin
                w  = mem[exp_pc];
                op = w[15:12];
                stop = (op == 4'hF) || (ILL_EN && op >= 4'h5 && op <= 4'hE);
                n_cmp++; if (dec_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, dec_pc, exp_pc); end
                n_cmp++; if ({dec_op, dec_rd, dec_mode, dec_operand} !== w) begin
                    n_err++; $display("FAIL rnd_fields c=%0d got %h exp %h", c, {dec_op, dec_rd, dec_mode, dec_operand}, w); end
                n_cmp++; if (dec_illegal !== (ILL_EN && op >= 4'h5 && op <= 4'hE)) begin
                    n_err++; $display("FAIL rnd_illegal c=%0d got %b op %h", c, dec_illegal, op); end
                if (dec_ready) begin
                    nhs++;
                    exp_pc = exp_pc + 8'd1;
                    m_halted = stop;
                end
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                m_halted = 1'b0;
            end
        end
        redirect_valid = 1'b0;
        n_cmp++; if (nhs < 100) begin n_err++; $display("FAIL rnd_progress got %0d exp >=100", nhs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_illegal();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode stage placed directly upstream of the R0/R1 execute datapath. It walks an 8-bit program counter through a synchronous 16-bit instruction memory and buffers returned words in a small prefetch FIFO. It splits each word into opcode, register, addressing-mode and operand fields and hands one decoded instruction per cycle to execute over a valid/ready handshake. Execute can redirect the PC, which flushes all prefetched and in-flight instructions.

## Interface
- RESET_PC, 8'd10, PC value loaded on reset and first fetch address
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  8  fetch address (current PC)
- imem_rdata  in  16  instruction word, valid with imem_rvalid
- imem_rvalid  in  1  response; always exactly 1 cycle after the imem_req it answers
- dec_valid  out  1  decoded instruction available
- dec_ready  in  1  execute accepts instruction
- dec_op  out  4  opcode = word[15:12]
- dec_rd  out  2  destination register = word[11:10]
- dec_mode  out  2  00 direct [addr], 01 register, 10 register-indirect, 11 immediate = word[9:8]
- dec_operand  out  8  word[7:0]
- dec_pc  out  8  address the instruction was fetched from
- dec_illegal  out  1  opcode undefined (see Configuration)
- redirect_valid  in  1  execute requests PC change
- redirect_pc  in  8  new PC
- halted  out  1  fetch stopped by HALT

## Operation
- Opcodes: 0 LOAD, 1 ADD, 2 SUB, 3 STORE, 4 JMP, F HALT; 5–E undefined.
- States: RUN, HALTED. Reset → RUN, PC=RESET_PC, FIFO empty, epoch=0.
- RUN: assert imem_req with imem_addr=PC when (fifo_count + inflight) < FIFO_DEPTH, counting a slot freed by a same-cycle pop; PC increments on each request, wraps 8'hFF→8'h00.
- Response: imem_rvalid with matching epoch pushes {word, pc} into FIFO. The FIFO cannot overflow by construction. An overflow is an assertion failure.
- Decoded fields are combinational from the FIFO head; dec_valid = FIFO not empty. Pop on dec_valid & dec_ready.
- HALT word pushed into FIFO → state HALTED, halted=1, no further requests. Any later response is discarded. The HALT itself is still presented to execute.
- Redirect, any state: PC←redirect_pc, FIFO cleared, epoch toggles so a response in flight is dropped, state→RUN. Fetch from redirect_pc starts the next cycle.
- Redirect and handshake in the same cycle: the handshake completes (instruction consumed), then the flush applies.
- Execute stalls (dec_ready=0): FIFO fills, imem_req drops; no instruction lost or duplicated.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_op/rd/mode/operand/pc=0, dec_illegal=0, halted=0.
- First req in cycle 1 after rst_n rises. Word in FIFO cycle 2. dec_valid=1 in cycle 2 (combinational head).
- Fetch-to-decode latency 2 cycles; sustained throughput 1 instr/cycle with dec_ready held high.
- Redirect asserted in cycle N: dec_valid=0 in cycle N+1; imem_req with redirect_pc in N+1; first new dec_valid in N+2.
- rst_n low mid-operation overrides everything including redirect. State returns to reset values on the next edge.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined: undefined opcodes (5–E) raise dec_illegal=1 with the instruction. Pushing one stops fetch exactly as HALT does (halted=1).
- Not defined: dec_illegal tied 0. Undefined opcodes pass through unchanged with dec_op as fetched, and fetch continues.

## Test plan
- Reset, memory[10..12]=16'h0000,16'h1201,16'hF000, dec_ready=1 → dec_pc 10,11,12 on cycles 2,3,4; dec_op 0,1,F; halted=1 from cycle 4; no imem_req after cycle 3.
- dec_ready=0 for 6 cycles from cycle 2 → FIFO holds 2 entries, imem_req=0. On release, pcs 10,11,12… in order with no gap or duplicate.
- Redirect to 8'h40 in the cycle a response for pc 13 is in flight → pc 13 never appears; next dec_pc=8'h40 two cycles later.
- RESET_PC=8'hFE, stream of ADDs → dec_pc sequence FE, FF, 00, 01.
- With DECODE_ILLEGAL_CHECK_EN, word 16'h7000 at pc 11 → dec_illegal=1 with dec_pc=11, halted=1. Without the macro, dec_op=7, dec_illegal=0, fetch continues.
- rst_n low for 1 cycle while FIFO is full and halted → all outputs at reset values; fetch restarts at RESET_PC.
